// File: rtl/score_pkg.sv
// score_pkg: glyph codes, text-box geometry and the BCD score type shared by the score renderer.
package score_pkg;
  localparam logic [3:0] GLYPH_S = 4'd0;
  localparam logic [3:0] GLYPH_C = 4'd1;
  localparam logic [3:0] GLYPH_O = 4'd2;
  localparam logic [3:0] GLYPH_R = 4'd3;
  localparam logic [3:0] GLYPH_E = 4'd4;
  localparam logic [3:0] GLYPH_DIGIT0 = 4'd5;
  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 16;
  localparam int TEXT_LEN = 10;
  localparam logic [3:0] BLANK_SLOT = 4'd5;
  typedef logic [3:0][3:0] bcd4_t;
endpackage

// File: rtl/score_renderer_bcd_counter4.sv
// bcd_counter4: saturating 4-digit BCD counter; ports clk/rst, clr (priority), inc, bcd value out, sat high at 9999.
module bcd_counter4
  import score_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  inc,
  output bcd4_t bcd,
  output logic  sat
);
  bcd4_t bcd_d, bcd_q;
  logic cy;
  assign bcd = bcd_q;
  assign sat = bcd_q == 16'h9999;
  always_comb begin
    bcd_d = bcd_q;
    cy = inc & ~sat;
    for (int i = 0; i < 4; i++) begin
      bcd_d[i] = cy ? (bcd_q[i] == 4'd9 ? 4'd0 : bcd_q[i] + 4'd1) : bcd_q[i];
      cy = cy & (bcd_q[i] == 4'd9);
    end
    bcd_d = clr ? '0 : bcd_d;
  end
  always_ff @(posedge clk) bcd_q <= rst ? '0 : bcd_d;
endmodule

// File: rtl/score_renderer.sv
// score_renderer: draws "SCORE dddd" at (X0,Y0); ports Clk/Reset, score_inc/score_clr/frame_start, DrawX/DrawY in, rom_addr/rom_data glyph ROM link, pixel_on (2-clock latency), score_bcd/score_sat live score.
module score_renderer
  import score_pkg::*;
#(
  parameter int unsigned X0 = 16,
  parameter int unsigned Y0 = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        score_inc,
  input  logic        score_clr,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [8:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        pixel_on,
  output logic [15:0] score_bcd,
  output logic        score_sat
);
  logic [9:0] dx, dy;
  logic [3:0] slot, glyph, col_d, col_q;
  logic [1:0] d_idx;
  logic in_box, valid_d, valid_q, pixel_on_d, pixel_on_q;
  logic [8:0] rom_addr_d, rom_addr_q;
  bcd4_t score, shadow_d, shadow_q;
  bcd_counter4 u_cnt (
    .clk(Clk),
    .rst(Reset),
    .clr(score_clr),
    .inc(score_inc),
    .bcd(score),
    .sat(score_sat)
  );
  assign score_bcd = score;
  assign rom_addr = rom_addr_q;
  assign pixel_on = pixel_on_q;
  always_comb begin
    dx = DrawX - 10'(X0);
    dy = DrawY - 10'(Y0);
    // explicit compares reject coordinates left of / above the box that would wrap into it
    in_box = DrawX >= 10'(X0) && DrawY >= 10'(Y0) && dx < 10'(TEXT_LEN * GLYPH_W) && dy < 10'(GLYPH_H);
    slot = dx[7:4];
    col_d = dx[3:0];
    valid_d = in_box && slot != BLANK_SLOT;
    // slots 6..9 show thousands..units of the frame shadow
    d_idx = 2'(4'd9 - slot);
    glyph = slot == 4'd0 ? GLYPH_S :
            slot == 4'd1 ? GLYPH_C :
            slot == 4'd2 ? GLYPH_O :
            slot == 4'd3 ? GLYPH_R :
            slot == 4'd4 ? GLYPH_E : GLYPH_DIGIT0 + shadow_q[d_idx];
    rom_addr_d = valid_d ? {1'b0, glyph, dy[3:0]} : rom_addr_q;
    pixel_on_d = valid_q & rom_data[4'd15 - col_q];
    shadow_d = frame_start ? score : shadow_q;
  end
  always_ff @(posedge Clk) begin
    rom_addr_q <= Reset ? '0 : rom_addr_d;
    col_q <= Reset ? '0 : col_d;
    valid_q <= Reset ? 1'b0 : valid_d;
    pixel_on_q <= Reset ? 1'b0 : pixel_on_d;
    shadow_q <= Reset ? '0 : shadow_d;
  end
endmodule

// File: tb/tb_score_renderer.sv
// tb_score_renderer: directed and random stimulus against an arithmetic reference model of the score renderer.
module tb_score_renderer;
  localparam int X0 = 16;
  localparam int Y0 = 16;
  logic Clk = 1'b0;
  logic Reset, score_inc, score_clr, frame_start;
  logic [9:0] DrawX, DrawY;
  logic [8:0] rom_addr;
  logic [15:0] rom_data, score_bcd;
  logic pixel_on, score_sat;
  logic [15:0] rom [0:511];
  int passed = 0;
  int total = 0;
  int m_score, m_shadow, m_addr, m_col;
  bit m_valid, m_pix;
  always #5 Clk = ~Clk;
  assign rom_data = rom[rom_addr];
  score_renderer #(.X0(X0), .Y0(Y0)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .score_inc(score_inc),
    .score_clr(score_clr),
    .frame_start(frame_start),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .pixel_on(pixel_on),
    .score_bcd(score_bcd),
    .score_sat(score_sat)
  );
  function automatic int digit(int v, int k);
    for (int i = 0; i < k; i++) v = v / 10;
    return v % 10;
  endfunction
  function automatic logic [15:0] to_bcd(int v);
    return {4'(digit(v, 3)), 4'(digit(v, 2)), 4'(digit(v, 1)), 4'(digit(v, 0))};
  endfunction
  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask
  task automatic cyc(bit rst, bit inc, bit clr, bit fs, int x, int y);
    int dxl, dyl, s;
    bit v;
    Reset = rst;
    score_inc = inc;
    score_clr = clr;
    frame_start = fs;
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge Clk);
    #1;
    if (rst) begin
      m_score = 0;
      m_shadow = 0;
      m_valid = 0;
      m_pix = 0;
      m_addr = 0;
      m_col = 0;
    end else begin
      m_pix = m_valid && rom[m_addr][15 - m_col];
      dxl = x - X0;
      dyl = y - Y0;
      v = dxl >= 0 && dxl < 160 && dyl >= 0 && dyl < 16 && dxl / 16 != 5;
      if (v) begin
        s = dxl / 16;
        m_addr = (s < 5 ? s : 5 + digit(m_shadow, 9 - s)) * 16 + dyl;
        m_col = dxl % 16;
      end
      m_valid = v;
      if (fs) m_shadow = m_score;
      m_score = clr ? 0 : (inc && m_score < 9999) ? m_score + 1 : m_score;
    end
    chk("rom_addr", 16'(rom_addr), 16'(m_addr));
    chk("pixel_on", 16'(pixel_on), 16'(m_pix));
    chk("score_bcd", score_bcd, to_bcd(m_score));
    chk("score_sat", 16'(score_sat), 16'(m_score == 9999));
  endtask
  initial begin
    int ox[5];
    int oy[5];
    for (int i = 0; i < 512; i++) rom[i] = 16'($urandom);
    rom[3] = 16'h0F00;
    repeat (2) cyc(1, 0, 0, 0, $urandom_range(0, 1023), $urandom_range(0, 1023));
    chk("reset_pixel", 16'(pixel_on), 16'h0);
    chk("reset_addr", 16'(rom_addr), 16'h0);
    chk("reset_score", score_bcd, 16'h0000);
    repeat (37) cyc(0, 1, 0, 0, 0, 0);
    chk("live37", score_bcd, 16'h0037);
    cyc(0, 0, 0, 0, X0 + 128, Y0 + 3);
    chk("d1_before_frame", 16'(rom_addr), 16'd83);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, X0 + 128, Y0 + 3);
    chk("d1_after_frame", 16'(rom_addr), 16'd131);
    cyc(0, 0, 0, 0, X0, Y0 + 3);
    chk("s_row3_addr", 16'(rom_addr), 16'd3);
    cyc(0, 0, 0, 0, X0 + 4, Y0 + 3);
    chk("s_col0_pixel", 16'(pixel_on), 16'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("s_col4_pixel", 16'(pixel_on), 16'd1);
    repeat (400) cyc(0, $urandom_range(0, 1), $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, X0 + 200), $urandom_range(0, Y0 + 24));
    cyc(0, 0, 1, 0, 0, 0);
    repeat (9999) cyc(0, 1, 0, 0, 0, 0);
    chk("sat_value", score_bcd, 16'h9999);
    chk("sat_flag", 16'(score_sat), 16'd1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("sat_hold", score_bcd, 16'h9999);
    cyc(0, 0, 1, 0, 0, 0);
    chk("sat_clr", score_bcd, 16'h0000);
    chk("sat_clr_flag", 16'(score_sat), 16'd0);
    repeat (5) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("clr_over_inc", score_bcd, 16'h0000);
    repeat (41) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    chk("live_after_inc_fs", score_bcd, 16'h0042);
    cyc(0, 0, 0, 0, X0 + 144, Y0);
    chk("shadow_units", 16'(rom_addr), 16'd96);
    cyc(0, 0, 0, 0, X0 + 128, Y0);
    chk("shadow_tens", 16'(rom_addr), 16'd144);
    ox = '{X0 + 80, X0 + 95, X0 - 1, X0 + 160, X0 + 16};
    oy = '{Y0 + 2, Y0 + 2, Y0 + 2, Y0 + 2, Y0 + 16};
    cyc(0, 0, 0, 0, X0 + 16, Y0 + 2);
    chk("c_row2_addr", 16'(rom_addr), 16'd18);
    foreach (ox[i]) begin
      cyc(0, 0, 0, 0, ox[i], oy[i]);
      chk("oob_addr_hold", 16'(rom_addr), 16'd18);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("oob_pixel", 16'(pixel_on), 16'd0);
    cyc(0, 0, 0, 0, X0 + 4, Y0 + 3);
    cyc(1, 0, 0, 0, X0 + 4, Y0 + 3);
    chk("midreset_pixel", 16'(pixel_on), 16'd0);
    chk("midreset_score", score_bcd, 16'h0000);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
